mem_wb_writeback: RTL
=====================

MEM_WB_WRITEBACK -- requirements
Module: mem_wb_writeback

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning datapath/register data width.
REQ-002 SHALL have parameter REG_AW, default 5, meaning register-number width (32 registers).
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port stall, input, 1, hold MEM/WB contents this cycle.
REQ-006 SHALL have port flush, input, 1, load a bubble this cycle.
REQ-007 SHALL have ports in_valid (1), in_regwrite (1), in_memtoreg (1), inputs, MEM-stage control.
REQ-008 SHALL have ports in_writereg (REG_AW), in_alu_result (DATA_W), in_mem_data (DATA_W), inputs, MEM-stage payload.
REQ-009 SHALL have ports id_rs, id_rt, inputs, REG_AW each, source registers being read in ID.
REQ-010 SHALL have ports regwrite (1), writereg (REG_AW), writedata (DATA_W), outputs, register-file write port.
REQ-011 SHALL have ports bypass_rs, bypass_rt, outputs, 1 each, ID read must take writedata instead of the register-file value.
REQ-012 SHALL have port wb_valid, output, 1, a real instruction occupies WB.
REQ-013 SHALL have port retire_count, output, 32, instructions retired since reset.

Function
REQ-014 SHALL register all in_* fields into one MEM/WB stage; outputs reflect inputs exactly one clk edge later.
REQ-015 SHALL drive writedata = in_mem_data as registered when registered memtoreg=1, else registered in_alu_result.
REQ-016 SHALL assert regwrite only when wb_valid=1, registered regwrite=1 and writereg!=0 (writes to $zero suppressed).
REQ-017 SHALL, with stall=1 and flush=0, hold every stage register and retire_count unchanged.
REQ-018 SHALL, with flush=1 (regardless of stall), clear valid, regwrite and memtoreg at next edge; payload fields don't-care.
REQ-019 SHALL load in_valid=0 as a bubble: wb_valid=0, regwrite=0 next cycle.
REQ-020 SHALL increment retire_count on each edge where wb_valid=1 and stall=0; a held instruction counts once.
REQ-021 SHALL wrap retire_count from 0xFFFFFFFF to 0 without flag.
REQ-022 SHALL drive bypass_rs = regwrite && (id_rs == writereg), bypass_rt likewise, combinationally; both 0 when id_rs/id_rt is 0.
REQ-023 SHALL sustain one instruction per cycle with no stall or flush (no idle cycles inserted).

Reset
REQ-024 SHALL, on reset assertion, immediately clear wb_valid, regwrite, bypass_rs, bypass_rt, writereg, writedata, retire_count to 0, independent of clk.
REQ-025 SHALL ignore stall, flush and in_* while reset is high; first capture occurs at the first clk edge after deassertion.
REQ-026 SHALL discard an in-flight instruction if reset asserts mid-operation; it is not retired nor written.

Structure
REQ-027 SHALL place DATA_W/REG_AW defaults and the zero-register constant in the shared datapath package used by Register_File.
REQ-028 SHALL implement the pipeline register as one sub-module, mem_wb_reg, with stall/flush/reset; mux, qualification, bypass and counter live in the top.

Verification
REQ-029 SHALL check: reset pulse mid-run -> all outputs 0 at once, retire_count=0, no write after release until new valid input.
REQ-030 SHALL check: valid, regwrite=1, memtoreg=0, writereg=5, alu=0x1234, mem=0xBEEF -> next cycle regwrite=1, writereg=5, writedata=0x1234; Register_File reg 5 reads 0x1234 afterwards.
REQ-031 SHALL check: same with memtoreg=1 -> writedata=0xBEEF; writereg=0 with regwrite=1 -> regwrite output 0, reg 0 reads 0.
REQ-032 SHALL check: stall=1 for 3 cycles holding instruction -> outputs constant, retire_count increments by 1 total; stall=1 and flush=1 together -> bubble next cycle.
REQ-033 SHALL check: writereg=7 in WB, id_rs=7, id_rt=8 -> bypass_rs=1, bypass_rt=0; id_rs=0 -> bypass_rs=0.
REQ-034 SHALL check: retire_count forced/preloaded to 0xFFFFFFFF plus one retire -> 0x00000000.

Source files
------------

// File: rtl/mem_wb_writeback_pkg.sv
// Shared datapath constants for the MEM/WB writeback slice.
// Also used by the register file for its widths and the $zero index.
package mem_wb_writeback_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int REG_AW_DEF = 5;
  localparam int ZERO_REG   = 0;
  localparam int RETIRE_W   = 32;

endpackage

// File: rtl/mem_wb_writeback_reg.sv
// MEM/WB pipeline register: async reset, stall hold, flush to bubble.
// Payload is left untouched on flush; only control is cleared.
module mem_wb_reg
  import mem_wb_writeback_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_valid,
  input  logic              in_regwrite,
  input  logic              in_memtoreg,
  input  logic [REG_AW-1:0] in_writereg,
  input  logic [DATA_W-1:0] in_alu_result,
  input  logic [DATA_W-1:0] in_mem_data,
  output logic              q_valid,
  output logic              q_regwrite,
  output logic              q_memtoreg,
  output logic [REG_AW-1:0] q_writereg,
  output logic [DATA_W-1:0] q_alu_result,
  output logic [DATA_W-1:0] q_mem_data
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_valid      <= 1'b0;
      q_regwrite   <= 1'b0;
      q_memtoreg   <= 1'b0;
      q_writereg   <= '0;
      q_alu_result <= '0;
      q_mem_data   <= '0;
    end else if (flush) begin
      q_valid    <= 1'b0;
      q_regwrite <= 1'b0;
      q_memtoreg <= 1'b0;
    end else if (!stall) begin
      q_valid      <= in_valid;
      q_regwrite   <= in_regwrite;
      q_memtoreg   <= in_memtoreg;
      q_writereg   <= in_writereg;
      q_alu_result <= in_alu_result;
      q_mem_data   <= in_mem_data;
    end
  end

endmodule

// File: rtl/mem_wb_writeback.sv
// Writeback stage: result mux, $zero-suppressed write, ID bypass,
// and retired-instruction counter behind the MEM/WB register.
module mem_wb_writeback
  import mem_wb_writeback_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall,
  input  logic                flush,
  input  logic                in_valid,
  input  logic                in_regwrite,
  input  logic                in_memtoreg,
  input  logic [REG_AW-1:0]   in_writereg,
  input  logic [DATA_W-1:0]   in_alu_result,
  input  logic [DATA_W-1:0]   in_mem_data,
  input  logic [REG_AW-1:0]   id_rs,
  input  logic [REG_AW-1:0]   id_rt,
  output logic                regwrite,
  output logic [REG_AW-1:0]   writereg,
  output logic [DATA_W-1:0]   writedata,
  output logic                bypass_rs,
  output logic                bypass_rt,
  output logic                wb_valid,
  output logic [RETIRE_W-1:0] retire_count
);

  logic              q_regwrite;
  logic              q_memtoreg;
  logic [DATA_W-1:0] q_alu_result;
  logic [DATA_W-1:0] q_mem_data;
  logic [RETIRE_W-1:0] retire_q;

  mem_wb_reg #(
    .DATA_W (DATA_W),
    .REG_AW (REG_AW)
  ) u_reg (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .flush         (flush),
    .in_valid      (in_valid),
    .in_regwrite   (in_regwrite),
    .in_memtoreg   (in_memtoreg),
    .in_writereg   (in_writereg),
    .in_alu_result (in_alu_result),
    .in_mem_data   (in_mem_data),
    .q_valid       (wb_valid),
    .q_regwrite    (q_regwrite),
    .q_memtoreg    (q_memtoreg),
    .q_writereg    (writereg),
    .q_alu_result  (q_alu_result),
    .q_mem_data    (q_mem_data)
  );

  assign writedata = q_memtoreg ? q_mem_data : q_alu_result;

  // Non-zero destination also keeps bypass quiet for $zero reads
  assign regwrite = wb_valid && q_regwrite &&
                    (writereg != REG_AW'(ZERO_REG));

  assign bypass_rs = regwrite && (id_rs == writereg);
  assign bypass_rt = regwrite && (id_rt == writereg);

  // A stalled instruction is counted on the edge it finally leaves
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      retire_q <= '0;
    end else if (wb_valid && !stall) begin
      retire_q <= retire_q + 1'b1;
    end
  end

  assign retire_count = retire_q;

endmodule
